// File: rtl/seq_comparator.sv
// Sequential magnitude comparator. It compares two WIDTH-bit operands one SLICE-bit
// slice per clock, starting at the most-significant slice, and stops at the first slice that differs.
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Gt,
    output logic             Lt,
    output logic             Et
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             et_q, et_d;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [SLICE-1:0] a_top;
    logic [SLICE-1:0] b_top;
    logic             slice_gt;
    logic             slice_lt;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        a_in            = A;
        b_in            = B;
        a_in[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
        b_in[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
    end

    assign a_top    = a_q[WIDTH-1 -: SLICE];
    assign b_top    = b_q[WIDTH-1 -: SLICE];
    assign slice_gt = (a_top > b_top);
    assign slice_lt = (a_top < b_top);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        et_d    = et_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (slice_gt || slice_lt) begin
                    gt_d    = slice_gt;
                    lt_d    = slice_lt;
                    et_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LAST_IDX) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    et_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    a_d   = a_q << SLICE;
                    b_d   = b_q << SLICE;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            et_q    <= et_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Gt   = gt_q;
    assign Lt   = lt_q;
    assign Et   = et_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Randomised and directed bench for seq_comparator (WIDTH=16, SLICE=4). A scoreboard queue
// holds the expected results, and a negedge monitor checks the flags and the latency on each done pulse.
module tb_seq_comparator;

    localparam int W   = 16;
    localparam int SL  = 4;
    localparam int NSL = W / SL;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         Gt;
    logic         Lt;
    logic         Et;

    seq_comparator #(.WIDTH(W), .SLICE(SL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .Gt         (Gt),
        .Lt         (Lt),
        .Et         (Et)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [2:0]   flags;   // {gt, lt, et}
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   have_last = 0;
    logic [2:0] last_flags = 3'b000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // This reference model works on whole-operand arithmetic. It uses no slice shifting and no MSB flipping.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int acc);
        exp_t e;
        bit   found;
        e.a = a;
        e.b = b;
        e.s = s;
        e.acc = acc;
        if (s) e.flags = {($signed(a) > $signed(b)), ($signed(a) < $signed(b)), (a == b)};
        else   e.flags = {(a > b), (a < b), (a == b)};
        e.lat = NSL;
        found = 0;
        for (int i = 0; i < NSL; i++) begin
            if (!found && (a[W-1-SL*i -: SL] != b[W-1-SL*i -: SL])) begin
                e.lat = i + 1;
                found = 1;
            end
        end
        return e;
    endfunction

    // The caller is positioned #1 after a posedge. The task returns #1 after the accepting edge.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit hold);
        int t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout busy=%0b want 0 within 100 cycles", busy);
            return;
        end
        A = a;
        B = b;
        signed_mode = s;
        start = 1'b1;
        sb.push_back(model(a, b, s, cyc + 1));
        @(posedge clk); #1;
        A = W'($urandom);
        B = W'($urandom);
        signed_mode = 1'($urandom);
        if (!hold) start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done got done=1 want no done (no pending compare)");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks += 3;
                    if ({Gt, Lt, Et} !== e.flags) begin
                        errors++;
                        $display("FAIL flags a=%h b=%h s=%0b got GtLtEt=%b want %b", e.a, e.b, e.s, {Gt, Lt, Et}, e.flags);
                    end
                    if (cyc - e.acc != e.lat) begin
                        errors++;
                        $display("FAIL latency a=%h b=%h got %0d want %0d", e.a, e.b, cyc - e.acc, e.lat);
                    end
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_at_done got busy=%b want 0", busy);
                    end
                    $display("TXN a=%h b=%h signed=%0b GtLtEt=%b latency=%0d", e.a, e.b, e.s, {Gt, Lt, Et}, cyc - e.acc);
                    have_last  = 1;
                    last_flags = e.flags;
                end
            end else begin
                checks++;
                if ({Gt, Lt, Et} !== (have_last ? last_flags : 3'b000)) begin
                    errors++;
                    $display("FAIL flag_hold got GtLtEt=%b want %b", {Gt, Lt, Et}, have_last ? last_flags : 3'b000);
                end
            end
        end
    end

    initial begin
        int t;
        int k;
        int mode;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] lowmask;

        rst_n = 1'b0;
        start = 1'b1;
        signed_mode = 1'b0;
        A = 16'h1234;
        B = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_flags", 32'({Gt, Lt, Et}), 32'd0);

        // Release reset while start is already high. The start is accepted at the next edge.
        rst_n = 1'b1;
        sb.push_back(model(16'h1234, 16'h1234, 1'b0, cyc + 1));
        @(posedge clk); #1;
        chk("start_after_reset_busy", 32'(busy), 32'd1);
        start = 1'b0;

        do_cmp(16'h9000, 16'h1000, 1'b0, 0);
        do_cmp(16'h9000, 16'h1000, 1'b1, 0);
        do_cmp(16'h1235, 16'h1234, 1'b0, 0);
        do_cmp(16'hFFFF, 16'h0000, 1'b1, 0);
        do_cmp(16'h7FFF, 16'h8000, 1'b1, 0);

        // A start pulse while busy must be ignored.
        do_cmp(16'h1111, 16'h1111, 1'b0, 0);
        A = 16'h0001;
        B = 16'h0002;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // Hold start through done so that the compares run back to back.
        do_cmp(16'h00F0, 16'h0F00, 1'b0, 1);
        do_cmp(16'hABCD, 16'hABCD, 1'b1, 1);
        do_cmp(16'h0001, 16'h0000, 1'b0, 0);

        // Abort with an asynchronous reset two cycles into a four-cycle compare.
        do_cmp(16'h2222, 16'h2222, 1'b0, 0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'({Gt, Lt, Et}), 32'd0);
        sb.delete();
        have_last = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_cmp(16'h0003, 16'h0004, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 2));
            ra = W'($urandom);
            if (mode == 0) begin
                rb = W'($urandom);
            end else if (mode == 1) begin
                rb = ra;
            end else begin
                k = int'($urandom_range(0, NSL - 1));
                lowmask = W'((32'd1 << (SL * (NSL - 1 - k))) - 1);
                rb = ra ^ (W'(32'd1 << $urandom_range(0, SL - 1)) << (SL * (NSL - 1 - k)));
                rb = rb ^ (W'($urandom) & lowmask);
            end
            do_cmp(ra, rb, 1'($urandom), bit'($urandom_range(0, 1)));
        end
        start = 1'b0;

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sb.size());
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
